// File: rtl/icache_pkg.sv
// Shared types and AXI constants for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        AR,
        R,
        RESP
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [7:0] ICACHE_ARLEN   = 8'd3;

    // Memory beats arrive byte-reversed relative to the little-endian fetch word.
    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage: async read, per-word data write, per-line tag/valid write,
// single-cycle flash-clear of all valid bits.
module icache_array #(
    parameter int NSETS = 16,
    parameter int IW    = 4,
    parameter int TW    = 24
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [IW-1:0] index_i,
    input  logic [1:0]    word_i,
    output logic [TW-1:0] tag_o,
    output logic          valid_o,
    output logic [31:0]   word_o,
    input  logic          word_we_i,
    input  logic [1:0]    wr_word_i,
    input  logic [31:0]   wr_data_i,
    input  logic          line_we_i,
    input  logic [TW-1:0] line_tag_i,
    input  logic          line_valid_i,
    input  logic          clear_i
);
    logic [31:0]      data_q [NSETS][4];
    logic [TW-1:0]    tag_q  [NSETS];
    logic [NSETS-1:0] valid_q;

    assign tag_o   = tag_q[index_i];
    assign valid_o = valid_q[index_i];
    assign word_o  = data_q[index_i][word_i];

    // Data and tags are deliberately left unreset; valid bits guard them.
    always_ff @(posedge clk_i) begin
        if (word_we_i) begin
            data_q[index_i][wr_word_i] <= wr_data_i;
        end
        if (line_we_i) begin
            tag_q[index_i] <= line_tag_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (clear_i) begin
            valid_q <= '0;
        end else if (line_we_i) begin
            valid_q[index_i] <= line_valid_i;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache; misses refill a 16-byte line with one
// 4-beat AXI4 INCR burst.
//   state  | meaning
//   IDLE   | ready for a fetch request
//   LOOKUP | tag compare on the latched address
//   AR     | read address presented, waiting for arready
//   R      | accepting refill beats
//   RESP   | response held until the IFU takes it
module icache
    import icache_pkg::*;
#(
    parameter int NSETS      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_req_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [31:0] ifu_resp_inst,
    output logic        ifu_resp_err,
    input  logic        flush,
    output logic        io_master_arvalid,
    input  logic        io_master_arready,
    output logic [31:0] io_master_araddr,
    output logic [3:0]  io_master_arid,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic [1:0]  io_master_arburst,
    input  logic        io_master_rvalid,
    output logic        io_master_rready,
    input  logic [31:0] io_master_rdata,
    input  logic [1:0]  io_master_rresp,
    input  logic        io_master_rlast,
    input  logic [3:0]  io_master_rid,
    output logic [31:0] perf_hit,
    output logic [31:0] perf_miss
);
    localparam int IW = $clog2(NSETS);
    localparam int TW = 32 - 4 - IW;

    generate
        if (LINE_WORDS != 4) begin : g_bad_line_words
            $error("icache: LINE_WORDS must be 4");
        end
        if (NSETS < 2 || (NSETS & (NSETS - 1)) != 0) begin : g_bad_nsets
            $error("icache: NSETS must be a power of two, at least 2");
        end
    endgenerate

    state_e      state_q;
    logic [31:2] addr_q;
    logic [1:0]  beat_q;
    logic        err_q;
    logic        flush_pending_q;
    logic        arvalid_q;
    logic        resp_valid_q;
    logic [31:0] resp_inst_q;
    logic        resp_err_q;
    logic [31:0] perf_hit_q;
    logic [31:0] perf_miss_q;

    logic [IW-1:0] index;
    logic [1:0]    offset;
    logic [TW-1:0] tag;
    logic [TW-1:0] arr_tag;
    logic          arr_valid;
    logic [31:0]   arr_word;
    logic          hit;
    logic          beat_accept;
    logic          last_beat;
    logic          beat_err;
    logic          clear_valid;
    logic          unused_ok;

    assign index  = addr_q[4 +: IW];
    assign offset = addr_q[3:2];
    assign tag    = addr_q[31 -: TW];
    assign hit    = arr_valid && (arr_tag == tag);

    assign beat_accept = (state_q == R) && io_master_rvalid;
    assign last_beat   = io_master_rlast || (beat_q == 2'd3);
    assign beat_err    = err_q || (io_master_rresp != AXI_RESP_OKAY)
                       || (io_master_rlast != (beat_q == 2'd3));

    // Deferred flush lands on the RESP->IDLE edge, when no line write is in progress.
    assign clear_valid = (flush && (state_q == IDLE || state_q == LOOKUP))
                       || (state_q == RESP && ifu_resp_ready && (flush_pending_q || flush));

    icache_array #(
        .NSETS(NSETS),
        .IW   (IW),
        .TW   (TW)
    ) u_array (
        .clk_i       (clk),
        .rst_i       (reset),
        .index_i     (index),
        .word_i      (offset),
        .tag_o       (arr_tag),
        .valid_o     (arr_valid),
        .word_o      (arr_word),
        .word_we_i   (beat_accept),
        .wr_word_i   (beat_q),
        .wr_data_i   (bswap32(io_master_rdata)),
        .line_we_i   (beat_accept && last_beat),
        .line_tag_i  (tag),
        .line_valid_i(!beat_err && !flush_pending_q && !flush),
        .clear_i     (clear_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            beat_q          <= '0;
            err_q           <= 1'b0;
            flush_pending_q <= 1'b0;
            arvalid_q       <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_inst_q     <= '0;
            resp_err_q      <= 1'b0;
            perf_hit_q      <= '0;
            perf_miss_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ifu_req_valid) begin
                        addr_q  <= ifu_req_addr[31:2];
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        resp_inst_q  <= arr_word;
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                        perf_hit_q   <= perf_hit_q + 32'd1;
                        state_q      <= RESP;
                    end else begin
                        perf_miss_q <= perf_miss_q + 32'd1;
                        beat_q      <= '0;
                        err_q       <= 1'b0;
                        arvalid_q   <= 1'b1;
                        state_q     <= AR;
                    end
                end
                AR: begin
                    if (flush) flush_pending_q <= 1'b1;
                    if (io_master_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= R;
                    end
                end
                R: begin
                    if (flush) flush_pending_q <= 1'b1;
                    if (io_master_rvalid) begin
                        beat_q <= beat_q + 2'd1;
                        err_q  <= beat_err;
                        if (beat_q == offset) resp_inst_q <= bswap32(io_master_rdata);
                        if (last_beat) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= beat_err;
                            if (beat_err) resp_inst_q <= '0;
                            state_q <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (ifu_resp_ready) begin
                        resp_valid_q    <= 1'b0;
                        flush_pending_q <= 1'b0;
                        state_q         <= IDLE;
                    end else if (flush) begin
                        flush_pending_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ifu_req_ready     = (state_q == IDLE);
    assign io_master_rready  = (state_q == R);
    assign ifu_resp_valid    = resp_valid_q;
    assign ifu_resp_inst     = resp_inst_q;
    assign ifu_resp_err      = resp_err_q;
    assign io_master_arvalid = arvalid_q;
    assign io_master_araddr  = {addr_q[31:4], 4'b0000};
    assign io_master_arid    = 4'd0;
    assign io_master_arlen   = ICACHE_ARLEN;
    assign io_master_arsize  = AXI_SIZE_4B;
    assign io_master_arburst = AXI_BURST_INCR;
    assign perf_hit          = perf_hit_q;
    assign perf_miss         = perf_miss_q;

    assign unused_ok = ^{ifu_req_addr[1:0], io_master_rid};

endmodule
